// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the fetch/memory-stage bus arbiter: FSM states, owner
// identifiers, transfer size codes and the downstream request payload.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } arb_owner_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_payload_t;

    // Fetch traffic is always a full-word read.
    function automatic bus_payload_t inst_payload(input logic [31:0] addr);
        bus_payload_t p;
        p.wr    = 1'b0;
        p.size  = SIZE_W;
        p.wstrb = 4'b1111;
        p.addr  = addr;
        p.wdata = 32'h0;
        return p;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while fetch was waiting;
// full_o tells the arbiter that fetch must win the next address phase.
module arb_starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full_o = (cnt_q == CNT_W'(LIMIT));
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !full_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like port between fetch (read-only) and the memory stage.
// One outstanding transaction; data wins unless fetch has starved STARVE_LIMIT grants.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e state_q, state_d;
    arb_owner_e lock_q, lock_d;
    arb_owner_e owner_q, owner_d;
    arb_owner_e grant;

    bus_payload_t inst_pl, data_pl, grant_pl;

    logic             addr_accept;
    logic             starve_inc;
    logic             starve_clr;
    logic             starve_full;
    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        inst_pl       = inst_payload(inst_addr);
        data_pl.wr    = data_wr;
        data_pl.size  = data_size;
        data_pl.wstrb = data_wstrb;
        data_pl.addr  = data_addr;
        data_pl.wdata = data_wdata;
    end

    // Next-state and grant selection; REQ keeps the locked grantee until accepted.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        grant   = OWN_NONE;
        case (state_q)
            ARB_IDLE: begin
                if (data_req && !(inst_req && starve_full)) begin
                    grant = OWN_DATA;
                end else if (inst_req) begin
                    grant = OWN_INST;
                end
                if (grant != OWN_NONE) begin
                    if (bus_addr_ok) begin
                        owner_d = grant;
                        state_d = ARB_WAIT;
                    end else begin
                        lock_d  = grant;
                        state_d = ARB_REQ;
                    end
                end
            end
            ARB_REQ: begin
                grant = lock_q;
                if (bus_addr_ok) begin
                    owner_d = lock_q;
                    lock_d  = OWN_NONE;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus_data_ok) begin
                    owner_d = OWN_NONE;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign addr_accept = bus_addr_ok && (grant != OWN_NONE);
    assign starve_inc  = addr_accept && (grant == OWN_DATA) && inst_req;
    assign starve_clr  = addr_accept && !starve_inc;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (starve_inc),
        .clr_i  (starve_clr),
        .cnt_o  (starve_cnt),
        .full_o (starve_full)
    );

    // Outputs are forced quiet while rst is held so nothing leaks downstream.
    always_comb begin
        grant_pl = '0;
        case (grant)
            OWN_INST: grant_pl = inst_pl;
            OWN_DATA: grant_pl = data_pl;
            default:  grant_pl = '0;
        endcase

        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'b00;
        bus_wstrb    = 4'b0000;
        bus_addr     = 32'h0;
        bus_wdata    = 32'h0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        data_rdata   = 32'h0;

        if (!rst) begin
            bus_req      = (grant != OWN_NONE);
            bus_wr       = grant_pl.wr;
            bus_size     = grant_pl.size;
            bus_wstrb    = grant_pl.wstrb;
            bus_addr     = grant_pl.addr;
            bus_wdata    = grant_pl.wdata;
            inst_addr_ok = bus_addr_ok && (grant == OWN_INST);
            data_addr_ok = bus_addr_ok && (grant == OWN_DATA);
            if ((state_q == ARB_WAIT) && bus_data_ok) begin
                case (owner_q)
                    OWN_INST: begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = bus_rdata;
                    end
                    OWN_DATA: begin
                        data_data_ok = 1'b1;
                        data_rdata   = bus_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            lock_q  <= OWN_NONE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic against a transaction-level arbitration and memory model.
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic clear_inputs;
        inst_req = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        inst_req = 1; inst_addr = 32'hBFC00000;
        data_req = 1; data_wr = 1; data_addr = 32'h80000000; data_wdata = 32'hDEADBEEF;
        data_wstrb = 4'hF; data_size = 2;
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h55AA55AA;
        #2;
        checks++;
        if ({bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %05b want 00000",
                     {bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
        end
        checks++;
        if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, inst_rdata, data_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_payload: got addr=%08h wdata=%08h irdata=%08h drdata=%08h want all 0",
                     bus_addr, bus_wdata, inst_rdata, data_rdata);
        end
        do_reset();
        $display("txn reset: outputs quiet while rst high");
    endtask

    task automatic test_fetch_only;
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00000; bus_addr_ok = 1;
        #2;
        checks++;
        if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !==
            {1'b1, 1'b0, 2'd2, 4'hF, 32'hBFC00000, 32'h0}) begin
            errors++;
            $display("FAIL fetch_payload: got req=%0b wr=%0b size=%0d strb=%h addr=%08h wdata=%08h want 1 0 2 f bfc00000 0",
                     bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata);
        end
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_addr_ok: got inst=%0b data=%0b want 1 0", inst_addr_ok, data_addr_ok);
        end
        next_cycle();
        inst_req = 0; bus_addr_ok = 0;
        #2;
        checks++;
        if ({bus_req, inst_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_wait_idle: got req=%0b data_ok=%0b want 0 0", bus_req, inst_data_ok);
        end
        next_cycle();
        bus_data_ok = 1; bus_rdata = 32'h3C1D8000;
        #2;
        checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok, data_rdata} !== {1'b1, 32'h3C1D8000, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fetch_data: got iok=%0b irdata=%08h dok=%0b drdata=%08h want 1 3c1d8000 0 0",
                     inst_data_ok, inst_rdata, data_data_ok, data_rdata);
        end
        next_cycle();
        clear_inputs();
        $display("txn fetch_only: addr=bfc00000 rdata=%08h", 32'h3C1D8000);
    endtask

    task automatic test_simultaneous;
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00040;
        data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
        data_addr = 32'h80001004; data_wdata = 32'h12345678;
        #2;
        checks++;
        if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, inst_addr_ok} !==
            {1'b1, 1'b1, 4'hF, 32'h80001004, 32'h12345678, 1'b0}) begin
            errors++;
            $display("FAIL simul_data_first: got wr=%0b strb=%h addr=%08h wdata=%08h iok=%0b want 1 f 80001004 12345678 0",
                     bus_wr, bus_wstrb, bus_addr, bus_wdata, inst_addr_ok);
        end
        next_cycle();
        bus_addr_ok = 1;
        #2;
        checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL simul_data_accept: got dok=%0b iok=%0b want 1 0", data_addr_ok, inst_addr_ok);
        end
        next_cycle();
        data_req = 0; bus_addr_ok = 1;
        #2;
        checks++;
        if ({bus_req, inst_addr_ok} !== 2'b00) begin
            errors++;
            $display("FAIL simul_fetch_waits: got req=%0b iok=%0b want 0 0", bus_req, inst_addr_ok);
        end
        next_cycle();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0;
        #2;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL simul_data_ack: got dok=%0b iok=%0b want 1 0", data_data_ok, inst_data_ok);
        end
        next_cycle();
        bus_data_ok = 0; bus_addr_ok = 1;
        #2;
        checks++;
        if ({inst_addr_ok, bus_addr, bus_wr} !== {1'b1, 32'hBFC00040, 1'b0}) begin
            errors++;
            $display("FAIL simul_fetch_after: got iok=%0b addr=%08h wr=%0b want 1 bfc00040 0",
                     inst_addr_ok, bus_addr, bus_wr);
        end
        next_cycle();
        inst_req = 0; bus_addr_ok = 0;
        next_cycle();
        bus_data_ok = 1; bus_rdata = 32'hCAFEF00D;
        #2;
        checks++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL simul_fetch_data: got iok=%0b rdata=%08h want 1 cafef00d", inst_data_ok, inst_rdata);
        end
        next_cycle();
        clear_inputs();
        $display("txn simultaneous: data sw 80001004 then fetch bfc00040");
    endtask

    task automatic test_locked_grant;
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00100;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 4'hF; data_addr = 32'h80000200;
            end
            bus_addr_ok = (c == 3);
            #2;
            checks++;
            if ({bus_req, bus_addr, bus_wr, data_addr_ok, inst_addr_ok} !==
                {1'b1, 32'hBFC00100, 1'b0, 1'b0, (c == 3)}) begin
                errors++;
                $display("FAIL locked_cycle%0d: got addr=%08h wr=%0b dok=%0b iok=%0b want bfc00100 0 0 %0b",
                         c, bus_addr, bus_wr, data_addr_ok, inst_addr_ok, (c == 3));
            end
            next_cycle();
        end
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        next_cycle();
        bus_data_ok = 0; bus_addr_ok = 1;
        #2;
        checks++;
        if ({data_addr_ok, bus_addr} !== {1'b1, 32'h80000200}) begin
            errors++;
            $display("FAIL locked_then_data: got dok=%0b addr=%08h want 1 80000200", data_addr_ok, bus_addr);
        end
        next_cycle();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        next_cycle();
        clear_inputs();
        $display("txn locked_grant: fetch bfc00100 held through data request");
    endtask

    task automatic test_starvation;
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00200;
        data_req = 1; data_wr = 0; data_size = 2; data_wstrb = 4'hF; data_addr = 32'h80000010;
        for (int k = 0; k < 10; k++) begin
            logic exp_inst;
            exp_inst = ((k % (LIMIT + 1)) == LIMIT);
            bus_addr_ok = 1;
            #2;
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {exp_inst, !exp_inst}) begin
                errors++;
                $display("FAIL starve_grant%0d: got iok=%0b dok=%0b want %0b %0b",
                         k, inst_addr_ok, data_addr_ok, exp_inst, !exp_inst);
            end
            $display("txn starve grant %0d: %s", k, exp_inst ? "I" : "D");
            next_cycle();
            bus_addr_ok = 0;
            next_cycle();
            bus_data_ok = 1; bus_rdata = 32'h1000 + k;
            #2;
            checks++;
            if ({inst_data_ok, data_data_ok} !== {exp_inst, !exp_inst}) begin
                errors++;
                $display("FAIL starve_route%0d: got iok=%0b dok=%0b want %0b %0b",
                         k, inst_data_ok, data_data_ok, exp_inst, !exp_inst);
            end
            next_cycle();
            bus_data_ok = 0;
        end
        clear_inputs();
    endtask

    task automatic test_byte_store;
        do_reset();
        data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'b1000;
        data_addr = 32'h80000003; data_wdata = 32'hAB000000; bus_addr_ok = 1;
        #2;
        checks++;
        if ({bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, data_addr_ok} !==
            {1'b1, 1'b1, 2'd0, 4'b1000, 32'h80000003, 32'hAB000000, 1'b1}) begin
            errors++;
            $display("FAIL byte_store: got wr=%0b size=%0d strb=%b addr=%08h wdata=%08h dok=%0b want 1 0 1000 80000003 ab000000 1",
                     bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, data_addr_ok);
        end
        next_cycle();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
        next_cycle();
        clear_inputs();
        $display("txn byte_store: sb 80000003 ab000000");
    endtask

    task automatic test_reset_in_wait;
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC00300; bus_addr_ok = 1;
        next_cycle();
        inst_req = 0; bus_addr_ok = 0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        next_cycle();
        bus_data_ok = 1; bus_rdata = 32'h77777777;
        #2;
        checks++;
        if ({inst_data_ok, data_data_ok, inst_rdata, bus_req} !== '0) begin
            errors++;
            $display("FAIL stray_data_ok: got iok=%0b dok=%0b irdata=%08h req=%0b want 0 0 0 0",
                     inst_data_ok, data_data_ok, inst_rdata, bus_req);
        end
        next_cycle();
        bus_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00400; bus_addr_ok = 1;
        #2;
        checks++;
        if ({inst_addr_ok, bus_addr} !== {1'b1, 32'hBFC00400}) begin
            errors++;
            $display("FAIL post_reset_fetch: got iok=%0b addr=%08h want 1 bfc00400", inst_addr_ok, bus_addr);
        end
        next_cycle();
        inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h24080001;
        #2;
        checks++;
        if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h24080001}) begin
            errors++;
            $display("FAIL post_reset_data: got iok=%0b rdata=%08h want 1 24080001", inst_data_ok, inst_rdata);
        end
        next_cycle();
        clear_inputs();
        $display("txn reset_in_wait: stray ack dropped, fetch bfc00400 ok");
    endtask

    task automatic test_random;
        logic [31:0] ref_mem   [0:63];
        logic [31:0] slave_mem [0:63];
        logic [31:0] exp_rd, s_rdata;
        logic        i_act, i_wait, d_act, d_wait, s_busy;
        int          m_cnt, m_lock, m_out, g, s_delay, n_done;
        logic [1:0]  off;
        logic [5:0]  idx;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]   = $urandom;
            slave_mem[i] = ref_mem[i];
        end
        do_reset();
        i_act = 0; i_wait = 0; d_act = 0; d_wait = 0; s_busy = 0; s_delay = 0; s_rdata = 0;
        m_cnt = 0; m_lock = 0; m_out = 0; n_done = 0; exp_rd = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            inst_req    = i_act;
            data_req    = d_act;
            bus_addr_ok = !s_busy && ($urandom_range(0, 1) == 1);
            bus_data_ok = s_busy && (s_delay == 0);
            bus_rdata   = bus_data_ok ? s_rdata : $urandom;
            #2;
            // who the arbitration rules say owns the address phase this cycle
            if (m_out != 0)                                 g = 0;
            else if (m_lock != 0)                           g = m_lock;
            else if (d_act && !(i_act && m_cnt == LIMIT))   g = 2;
            else if (i_act)                                 g = 1;
            else                                            g = 0;
            checks++;
            if (bus_req !== (g != 0)) begin
                errors++;
                $display("FAIL rnd_bus_req cyc%0d: got %0b want %0b", cyc, bus_req, (g != 0));
            end
            if (g == 1) begin
                checks++;
                if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {1'b0, 2'd2, 4'hF, inst_addr, 32'h0}) begin
                    errors++;
                    $display("FAIL rnd_inst_payload cyc%0d: got addr=%08h wr=%0b want %08h 0", cyc, bus_addr, bus_wr, inst_addr);
                end
            end else if (g == 2) begin
                checks++;
                if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !==
                    {data_wr, data_size, data_wstrb, data_addr, data_wdata}) begin
                    errors++;
                    $display("FAIL rnd_data_payload cyc%0d: got addr=%08h wdata=%08h want %08h %08h",
                             cyc, bus_addr, bus_wdata, data_addr, data_wdata);
                end
            end
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== {bus_addr_ok && g == 1, bus_addr_ok && g == 2}) begin
                errors++;
                $display("FAIL rnd_addr_ok cyc%0d: got iok=%0b dok=%0b want %0b %0b", cyc,
                         inst_addr_ok, data_addr_ok, bus_addr_ok && g == 1, bus_addr_ok && g == 2);
            end
            if (bus_data_ok && m_out != 0) begin
                checks++;
                if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !==
                    {m_out == 1, m_out == 2, (m_out == 1) ? exp_rd : 32'h0, (m_out == 2) ? exp_rd : 32'h0}) begin
                    errors++;
                    $display("FAIL rnd_data_ok cyc%0d: got iok=%0b dok=%0b ird=%08h drd=%08h want owner %0d rdata %08h",
                             cyc, inst_data_ok, data_data_ok, inst_rdata, data_rdata, m_out, exp_rd);
                end
                $display("txn rnd %0d: %s rdata=%08h", n_done, (m_out == 1) ? "INST" : "DATA", exp_rd);
                n_done++;
                m_out = 0;
            end else begin
                checks++;
                if ({inst_data_ok, data_data_ok} !== 2'b00) begin
                    errors++;
                    $display("FAIL rnd_idle_data_ok cyc%0d: got iok=%0b dok=%0b want 0 0", cyc, inst_data_ok, data_data_ok);
                end
            end
            // reference model: transaction accepted, memory image, starvation count
            if (g != 0 && bus_addr_ok) begin
                idx    = (g == 1) ? inst_addr[7:2] : data_addr[7:2];
                exp_rd = ref_mem[idx];
                if (g == 2 && data_wr) ref_mem[idx] = merge(ref_mem[idx], data_wdata, data_wstrb);
                if (g == 2 && i_act) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
                else                 m_cnt = 0;
                m_out  = g;
                m_lock = 0;
            end else if (g != 0) begin
                m_lock = g;
            end
            // environment: downstream slave and the two requesters
            if (s_busy) begin
                if (s_delay == 0) s_busy = 0;
                else              s_delay--;
            end else if (bus_addr_ok && bus_req) begin
                s_busy  = 1;
                s_delay = $urandom_range(0, 2);
                s_rdata = slave_mem[bus_addr[7:2]];
                if (bus_wr) slave_mem[bus_addr[7:2]] = merge(slave_mem[bus_addr[7:2]], bus_wdata, bus_wstrb);
            end
            if (inst_addr_ok) begin i_act = 0; i_wait = 1; end
            if (inst_data_ok) i_wait = 0;
            if (data_addr_ok) begin d_act = 0; d_wait = 1; end
            if (data_data_ok) d_wait = 0;
            if (!i_act && !i_wait && $urandom_range(0, 2) == 0) begin
                i_act     = 1;
                inst_addr = 32'hBFC00000 | (32'($urandom_range(0, 63)) << 2);
            end
            if (!d_act && !d_wait && $urandom_range(0, 1) == 0) begin
                d_act     = 1;
                data_size = 2'($urandom_range(0, 2));
                data_wr   = 1'($urandom_range(0, 1));
                case (data_size)
                    2'd0:    begin off = 2'($urandom_range(0, 3));     data_wstrb = 4'(4'b0001 << off); end
                    2'd1:    begin off = 2'(2 * $urandom_range(0, 1)); data_wstrb = 4'(4'b0011 << off); end
                    default: begin off = 2'd0;                          data_wstrb = 4'b1111;            end
                endcase
                data_addr  = 32'h80000000 | (32'($urandom_range(0, 63)) << 2) | 32'(off);
                data_wdata = $urandom;
            end
            next_cycle();
        end
        checks++;
        if (n_done < 100) begin
            errors++;
            $display("FAIL rnd_progress: got %0d completed transactions want at least 100", n_done);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_locked_grant();
        test_starvation();
        test_byte_store();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
